// File: rtl/spectrum_pkg.sv
// Shared widths, FSM encoding, coefficient defaults and saturation helper
// for the spectrum analyzer filter bank.
package spectrum_pkg;

  localparam int SAMPLE_W  = 8;
  localparam int STATE_W   = 16;
  localparam int COEF_W    = 8;
  localparam int PROD_W    = 24;
  localparam int SUM_W     = STATE_W + 2;
  localparam int FRAC_SH   = 8;
  localparam int MAX_BANDS = 8;

  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(32767);
  localparam logic signed [SUM_W-1:0] SAT_LO = -SUM_W'(32768);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FB_REQ,
    ST_FB_WAIT,
    ST_FF_REQ,
    ST_FF_WAIT,
    ST_DONE
  } state_e;

  function automatic logic signed [COEF_W-1:0] default_a(input int band);
    case (band)
      0:       return COEF_W'(20);
      1:       return COEF_W'(15);
      2:       return COEF_W'(10);
      3:       return COEF_W'(5);
      default: return '0;
    endcase
  endfunction

  function automatic logic signed [COEF_W-1:0] default_b(input int band);
    case (band)
      0:       return COEF_W'(10);
      1:       return COEF_W'(25);
      2:       return COEF_W'(30);
      3:       return COEF_W'(40);
      default: return '0;
    endcase
  endfunction

  // Clamp a widened state sum into the signed STATE_W range; never wraps.
  function automatic logic signed [STATE_W-1:0] sat_state(input logic signed [SUM_W-1:0] v);
    if (v > SAT_HI) begin
      return {1'b0, {(STATE_W-1){1'b1}}};
    end else if (v < SAT_LO) begin
      return {1'b1, {(STATE_W-1){1'b0}}};
    end else begin
      return v[STATE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/band_coeff_regfile.sv
// Runtime-writable per-band IIR coefficients (A feedback, B feedforward) with
// reset defaults; even address selects A, odd selects B, out-of-range writes dropped.
module band_coeff_regfile
  import spectrum_pkg::*;
#(
  parameter int NUM_BANDS = 4,
  parameter int BW        = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we_i,
  input  logic [3:0]        cfg_addr_i,
  input  logic [COEF_W-1:0] cfg_data_i,
  input  logic [BW-1:0]     a_idx_i,
  input  logic [BW-1:0]     b_idx_i,
  output logic [COEF_W-1:0] coef_a_o,
  output logic [COEF_W-1:0] coef_b_o
);

  logic [COEF_W-1:0] coef_a_q [NUM_BANDS];
  logic [COEF_W-1:0] coef_b_q [NUM_BANDS];
  logic              wr_ok;
  logic [BW-1:0]     wr_band;

  assign wr_ok   = cfg_we_i && (int'(cfg_addr_i) < 2 * NUM_BANDS);
  assign wr_band = cfg_addr_i[BW:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        coef_a_q[i] <= default_a(i);
        coef_b_q[i] <= default_b(i);
      end
    end else if (wr_ok) begin
      if (cfg_addr_i[0]) begin
        coef_b_q[wr_band] <= cfg_data_i;
      end else begin
        coef_a_q[wr_band] <= cfg_data_i;
      end
    end
  end

  assign coef_a_o = coef_a_q[a_idx_i];
  assign coef_b_o = coef_b_q[b_idx_i];

endmodule

// File: rtl/band_filter_scheduler.sv
// Time-multiplexes the per-band IIR update (y <= s, s <= sat(s - A*y + B*x)) onto
// one shared multiplier; four handshake states per band, then a one-cycle DONE pulse.
module band_filter_scheduler
  import spectrum_pkg::*;
#(
  parameter int NUM_BANDS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_strobe,
  input  logic [SAMPLE_W-1:0]          audio_sample,
  input  logic                         cfg_we,
  input  logic [3:0]                   cfg_addr,
  input  logic [COEF_W-1:0]            cfg_data,
  output logic                         mul_req,
  output logic [COEF_W-1:0]            mul_a,
  output logic [STATE_W-1:0]           mul_b,
  input  logic                         mul_gnt,
  input  logic                         mul_done,
  input  logic [PROD_W-1:0]            mul_p,
  output logic [NUM_BANDS*STATE_W-1:0] band_out,
  output logic                         band_valid,
  output logic                         busy,
  output logic                         overrun,
  input  logic                         overrun_clr
);

  localparam int BW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

  state_e                      state_q;
  logic [BW-1:0]               b_q;
  logic [BW-1:0]               b_nxt;
  logic signed [SAMPLE_W-1:0]  x_q;
  logic signed [STATE_W-1:0]   fb_q;
  logic signed [STATE_W-1:0]   s_q [NUM_BANDS];
  logic signed [STATE_W-1:0]   y_q [NUM_BANDS];
  logic                        mul_req_q;
  logic [COEF_W-1:0]           mul_a_q;
  logic [STATE_W-1:0]          mul_b_q;
  logic                        band_valid_q;
  logic                        overrun_q;
  logic                        overrun_d;
  logic signed [STATE_W-1:0]   prod_sh;
  logic signed [SUM_W-1:0]     sum_wide;
  logic signed [STATE_W-1:0]   s_d;
  logic [BW-1:0]               a_idx;
  logic [COEF_W-1:0]           coef_a;
  logic [COEF_W-1:0]           coef_b;

  assign b_nxt = b_q + BW'(1);
  // A is fetched for the band about to enter FB_REQ: band 0 from IDLE, else the next band.
  assign a_idx = (state_q == ST_IDLE) ? '0 : b_nxt;

  band_coeff_regfile #(
    .NUM_BANDS (NUM_BANDS),
    .BW        (BW)
  ) u_coeff (
    .clk        (clk),
    .rst        (rst),
    .cfg_we_i   (cfg_we),
    .cfg_addr_i (cfg_addr),
    .cfg_data_i (cfg_data),
    .a_idx_i    (a_idx),
    .b_idx_i    (b_q),
    .coef_a_o   (coef_a),
    .coef_b_o   (coef_b)
  );

  assign prod_sh  = STATE_W'($signed(mul_p) >>> FRAC_SH);
  assign sum_wide = SUM_W'(s_q[b_q]) - SUM_W'(fb_q) + SUM_W'(prod_sh);
  assign s_d      = sat_state(sum_wide);

  // A drop sets the flag even when a clear arrives in the same cycle.
  assign overrun_d = (sample_strobe && (state_q != ST_IDLE)) ? 1'b1 :
                     overrun_clr                             ? 1'b0 : overrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      b_q          <= '0;
      x_q          <= '0;
      fb_q         <= '0;
      mul_req_q    <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      band_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < NUM_BANDS; i++) begin
        s_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      band_valid_q <= 1'b0;
      overrun_q    <= overrun_d;
      case (state_q)
        ST_IDLE: begin
          if (sample_strobe) begin
            x_q       <= $signed(audio_sample);
            b_q       <= '0;
            mul_req_q <= 1'b1;
            mul_a_q   <= coef_a;
            mul_b_q   <= y_q[0];
            state_q   <= ST_FB_REQ;
          end
        end
        ST_FB_REQ: begin
          if (mul_gnt) begin
            mul_req_q <= 1'b0;
            state_q   <= ST_FB_WAIT;
          end
        end
        ST_FB_WAIT: begin
          if (mul_done) begin
            fb_q      <= prod_sh;
            mul_req_q <= 1'b1;
            mul_a_q   <= coef_b;
            mul_b_q   <= STATE_W'(x_q);
            state_q   <= ST_FF_REQ;
          end
        end
        ST_FF_REQ: begin
          if (mul_gnt) begin
            mul_req_q <= 1'b0;
            state_q   <= ST_FF_WAIT;
          end
        end
        ST_FF_WAIT: begin
          if (mul_done) begin
            y_q[b_q] <= s_q[b_q];
            s_q[b_q] <= s_d;
            if (b_q == BW'(NUM_BANDS - 1)) begin
              band_valid_q <= 1'b1;
              state_q      <= ST_DONE;
            end else begin
              b_q       <= b_nxt;
              mul_req_q <= 1'b1;
              mul_a_q   <= coef_a;
              mul_b_q   <= y_q[b_nxt];
              state_q   <= ST_FB_REQ;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  generate
    for (genvar g = 0; g < NUM_BANDS; g++) begin : g_pack
      assign band_out[g*STATE_W +: STATE_W] = y_q[g];
    end
  endgenerate

  assign mul_req    = mul_req_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign band_valid = band_valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_band_filter_scheduler.sv
// Self-checking bench: randomized samples/coefficients against an arithmetic
// reference of the per-band IIR update, plus latency, stall, overrun and reset scenarios.
module tb_band_filter_scheduler;

  localparam int NB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic               sample_strobe = 1'b0;
  logic [7:0]         audio_sample = '0;
  logic               cfg_we = 1'b0;
  logic [3:0]         cfg_addr = '0;
  logic [7:0]         cfg_data = '0;
  logic               overrun_clr = 1'b0;
  logic               mul_req;
  logic signed [7:0]  mul_a;
  logic signed [15:0] mul_b;
  logic               mul_gnt = 1'b1;
  logic               mul_done = 1'b0;
  logic [23:0]        mul_p = '0;
  logic [NB*16-1:0]   band_out;
  logic               band_valid;
  logic               busy;
  logic               overrun;

  band_filter_scheduler #(.NUM_BANDS(NB)) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_strobe (sample_strobe),
    .audio_sample  (audio_sample),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .mul_req       (mul_req),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_gnt       (mul_gnt),
    .mul_done      (mul_done),
    .mul_p         (mul_p),
    .band_out      (band_out),
    .band_valid    (band_valid),
    .busy          (busy),
    .overrun       (overrun),
    .overrun_clr   (overrun_clr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Multiplier model: grant decided mid-cycle, product returned the following cycle.
  int          stall_amt   = 0;
  int          stall_epoch = 0;
  logic        inject_done = 1'b0;
  int          seen_epoch  = 0;
  int          stall_left  = 0;
  logic        gnt_pend    = 1'b0;
  logic [23:0] p_pend      = '0;

  always @(negedge clk) begin
    mul_done = gnt_pend || inject_done;
    mul_p    = inject_done ? 24'h7F_FF00 : p_pend;
    if (seen_epoch != stall_epoch) begin
      seen_epoch = stall_epoch;
      stall_left = stall_amt;
    end
    if (mul_req && stall_left > 0) begin
      mul_gnt    = 1'b0;
      stall_left = stall_left - 1;
    end else begin
      mul_gnt = 1'b1;
    end
    gnt_pend = mul_req && mul_gnt;
    p_pend   = 24'(int'(mul_a) * int'(mul_b));
  end

  // Reference model of the filter bank.
  int mA [NB];
  int mB [NB];
  int ms [NB];
  int my [NB];

  function automatic void model_reset();
    int da [4];
    int db [4];
    da = '{20, 15, 10, 5};
    db = '{10, 25, 30, 40};
    for (int i = 0; i < NB; i++) begin
      mA[i] = (i < 4) ? da[i] : 0;
      mB[i] = (i < 4) ? db[i] : 0;
      ms[i] = 0;
      my[i] = 0;
    end
  endfunction

  function automatic void model_cfg(input int addr, input int data);
    if (addr < 2 * NB) begin
      if (addr % 2 == 1) mB[addr / 2] = data;
      else               mA[addr / 2] = data;
    end
  endfunction

  function automatic void model_sample(input int x);
    for (int b = 0; b < NB; b++) begin
      int fb, ff, t;
      fb = (mA[b] * my[b]) >>> 8;
      ff = (mB[b] * x) >>> 8;
      t  = ms[b] - fb + ff;
      if (t > 32767)  t = 32767;
      if (t < -32768) t = -32768;
      my[b] = ms[b];
      ms[b] = t;
    end
  endfunction

  function automatic logic [NB*16-1:0] model_out();
    logic [NB*16-1:0] r;
    for (int b = 0; b < NB; b++) r[b*16 +: 16] = 16'(my[b]);
    return r;
  endfunction

  function automatic int y_of(input int b);
    return int'($signed(band_out[b*16 +: 16]));
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; sample_strobe = 1'b0; cfg_we = 1'b0; overrun_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic do_cfg(input int addr, input int data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_data = 8'(data);
    @(negedge clk);
    cfg_we = 1'b0;
    model_cfg(addr, data);
  endtask

  // Waits (bounded) for band_valid; k=1 is the current negedge. lat=0 on timeout.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 1; k <= 300; k++) begin
      if (band_valid === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_sample(input int x, input int stall, output int lat, output logic stable,
                            output logic signed [7:0] a0, output logic signed [15:0] b0);
    @(posedge clk);
    stall_amt   = stall;
    stall_epoch = stall_epoch + 1;
    @(negedge clk);
    sample_strobe = 1'b1; audio_sample = 8'(x);
    @(negedge clk);
    sample_strobe = 1'b0;
    lat = 0; stable = 1'b1; a0 = mul_a; b0 = mul_b;
    for (int k = 1; k <= 300; k++) begin
      if (k <= stall + 1 && !(mul_req === 1'b1 && mul_a === a0 && mul_b === b0)) stable = 1'b0;
      if (band_valid === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    model_sample(x);
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (band_valid !== 1'b0) $display("FAIL reset_band_valid got=%b exp=0", band_valid); else n_pass++;
    n_checks++; if (mul_req !== 1'b0) $display("FAIL reset_mul_req got=%b exp=0", mul_req); else n_pass++;
    n_checks++; if (mul_a !== 8'sd0 || mul_b !== 16'sd0) $display("FAIL reset_operands got=%0d,%0d exp=0,0", mul_a, mul_b); else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun got=%b exp=0", overrun); else n_pass++;
    n_checks++; if (band_out !== '0) $display("FAIL reset_band_out got=%h exp=0", band_out); else n_pass++;
  endtask

  task automatic test_defaults();
    int lat; logic st; logic signed [7:0] a0; logic signed [15:0] b0;
    run_sample(64, 0, lat, st, a0, b0);
    n_checks++; if (lat !== 17) $display("FAIL default_latency got=%0d exp=17", lat); else n_pass++;
    n_checks++; if (a0 !== 8'sd20 || b0 !== 16'sd0) $display("FAIL default_first_operands got=%0d,%0d exp=20,0", a0, b0); else n_pass++;
    n_checks++; if (band_out !== model_out()) $display("FAIL default_first got=%h exp=%h", band_out, model_out()); else n_pass++;
    run_sample(64, 0, lat, st, a0, b0);
    n_checks++; if (band_out !== 64'h000A_0007_0006_0002) $display("FAIL default_second got=%h exp=000a000700060002", band_out); else n_pass++;
    n_checks++; if (band_out !== model_out()) $display("FAIL default_second_model got=%h exp=%h", band_out, model_out()); else n_pass++;
  endtask

  task automatic test_negative();
    int lat; logic st; logic signed [7:0] a0; logic signed [15:0] b0;
    apply_reset();
    run_sample(-128, 0, lat, st, a0, b0);
    run_sample(-128, 0, lat, st, a0, b0);
    n_checks++; if (y_of(3) !== -20) $display("FAIL neg_y3 got=%0d exp=-20", y_of(3)); else n_pass++;
    n_checks++; if (y_of(0) !== -5) $display("FAIL neg_y0 got=%0d exp=-5", y_of(0)); else n_pass++;
    n_checks++; if (band_out !== model_out()) $display("FAIL neg_model got=%h exp=%h", band_out, model_out()); else n_pass++;
  endtask

  task automatic test_random();
    int lat; logic st; logic signed [7:0] a0; logic signed [15:0] b0;
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1) do_cfg(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)) - 128);
      run_sample(int'($urandom_range(0, 255)) - 128, 0, lat, st, a0, b0);
      n_checks++; if (band_out !== model_out()) $display("FAIL random_%0d got=%h exp=%h", i, band_out, model_out()); else n_pass++;
    end
  endtask

  task automatic test_saturation();
    int lat; logic st; logic signed [7:0] a0; logic signed [15:0] b0; int prev;
    apply_reset();
    do_cfg(0, -128);
    do_cfg(1, 127);
    do_cfg(9, 99);
    prev = 0;
    for (int i = 0; i < 40; i++) begin
      run_sample(127, 0, lat, st, a0, b0);
      n_checks++; if (band_out !== model_out()) $display("FAIL sat_model_%0d got=%h exp=%h", i, band_out, model_out()); else n_pass++;
      n_checks++; if (y_of(0) < prev) $display("FAIL sat_monotonic_%0d got=%0d exp>=%0d", i, y_of(0), prev); else n_pass++;
      prev = y_of(0);
    end
    n_checks++; if (y_of(0) !== 32767) $display("FAIL sat_hold got=%0d exp=32767", y_of(0)); else n_pass++;
  endtask

  task automatic test_grant_stall();
    int lat; logic st; logic signed [7:0] a0; logic signed [15:0] b0; int exp_a; int exp_b;
    exp_a = mA[0]; exp_b = my[0];
    run_sample(50, 5, lat, st, a0, b0);
    n_checks++; if (lat !== 22) $display("FAIL stall_latency got=%0d exp=22", lat); else n_pass++;
    n_checks++; if (st !== 1'b1) $display("FAIL stall_req_stable got=%b exp=1", st); else n_pass++;
    n_checks++; if (int'(a0) !== exp_a || int'(b0) !== exp_b) $display("FAIL stall_operands got=%0d,%0d exp=%0d,%0d", a0, b0, exp_a, exp_b); else n_pass++;
    n_checks++; if (band_out !== model_out()) $display("FAIL stall_model got=%h exp=%h", band_out, model_out()); else n_pass++;
    run_sample(-30, 0, lat, st, a0, b0);
    n_checks++; if (lat !== 17) $display("FAIL stall_after_latency got=%0d exp=17", lat); else n_pass++;
  endtask

  task automatic test_overrun();
    int lat;
    @(negedge clk); sample_strobe = 1'b1; audio_sample = 8'(30);
    @(negedge clk); sample_strobe = 1'b0;
    repeat (3) @(negedge clk);
    sample_strobe = 1'b1; audio_sample = 8'(-100);
    @(negedge clk); sample_strobe = 1'b0;
    n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_set got=%b exp=1", overrun); else n_pass++;
    wait_valid(lat);
    model_sample(30);
    n_checks++; if (lat == 0 || band_out !== model_out()) $display("FAIL ovr_dropped lat=%0d got=%h exp=%h", lat, band_out, model_out()); else n_pass++;
    @(negedge clk); overrun_clr = 1'b1;
    @(negedge clk); overrun_clr = 1'b0;
    n_checks++; if (overrun !== 1'b0) $display("FAIL ovr_clear got=%b exp=0", overrun); else n_pass++;
    // Strobe landing in the DONE cycle is also dropped.
    @(negedge clk); sample_strobe = 1'b1; audio_sample = 8'(40);
    @(negedge clk); sample_strobe = 1'b0;
    wait_valid(lat);
    sample_strobe = 1'b1; audio_sample = 8'(77);
    @(negedge clk); sample_strobe = 1'b0;
    model_sample(40);
    n_checks++; if (overrun !== 1'b1 || busy !== 1'b0) $display("FAIL ovr_done got=%b,%b exp=1,0", overrun, busy); else n_pass++;
    n_checks++; if (band_out !== model_out()) $display("FAIL ovr_done_model got=%h exp=%h", band_out, model_out()); else n_pass++;
    @(negedge clk); overrun_clr = 1'b1;
    @(negedge clk); overrun_clr = 1'b0;
    @(negedge clk); sample_strobe = 1'b1; audio_sample = 8'(10);
    @(negedge clk); sample_strobe = 1'b0;
    repeat (2) @(negedge clk);
    sample_strobe = 1'b1; overrun_clr = 1'b1; audio_sample = 8'(55);
    @(negedge clk); sample_strobe = 1'b0; overrun_clr = 1'b0;
    n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_set_wins got=%b exp=1", overrun); else n_pass++;
    wait_valid(lat);
    model_sample(10);
    n_checks++; if (lat == 0 || band_out !== model_out()) $display("FAIL ovr_clr_model lat=%0d got=%h exp=%h", lat, band_out, model_out()); else n_pass++;
    @(negedge clk); overrun_clr = 1'b1;
    @(negedge clk); overrun_clr = 1'b0;
  endtask

  task automatic test_reset_midflight();
    int lat; logic st; logic signed [7:0] a0; logic signed [15:0] b0;
    do_cfg(0, 99);
    @(negedge clk); sample_strobe = 1'b1; audio_sample = 8'(20);
    @(negedge clk); sample_strobe = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (band_out !== '0) $display("FAIL mid_rst_band_out got=%h exp=0", band_out); else n_pass++;
    n_checks++; if (mul_req !== 1'b0 || band_valid !== 1'b0) $display("FAIL mid_rst_outputs got=%b,%b exp=0,0", mul_req, band_valid); else n_pass++;
    @(posedge clk); inject_done = 1'b1;
    @(posedge clk); inject_done = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || band_out !== '0 || band_valid !== 1'b0) $display("FAIL late_done got=%b,%h,%b exp=0,0,0", busy, band_out, band_valid); else n_pass++;
    run_sample(64, 0, lat, st, a0, b0);
    n_checks++; if (a0 !== 8'sd20) $display("FAIL mid_rst_coef_default got=%0d exp=20", a0); else n_pass++;
    n_checks++; if (lat !== 17) $display("FAIL mid_rst_latency got=%0d exp=17", lat); else n_pass++;
    run_sample(64, 0, lat, st, a0, b0);
    n_checks++; if (band_out !== model_out()) $display("FAIL mid_rst_model got=%h exp=%h", band_out, model_out()); else n_pass++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_defaults();
    test_negative();
    test_random();
    test_saturation();
    test_grant_stall();
    test_overrun();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/band_filter_scheduler.md
Name: band_filter_scheduler

Overview:
Sequences the per-band IIR update of the spectrum analyzer filter bank onto one shared 8x16 signed multiplier, instead of four parallel multiplier pairs. On each accepted sample strobe it walks bands 0..NUM_BANDS-1 and issues two multiplies per band: feedback A*y and feedforward B*x. It then updates the per-band state and output registers and pulses band_valid when all bands are done. It also owns the runtime-writable coefficient registers that configure the filter bank.

Parameters:
NUM_BANDS, 4, number of frequency bands (2..8)
SAMPLE_W, 8, signed audio sample width
STATE_W, 16, signed filter state/output width
COEF_W, 8, signed coefficient width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
sample_strobe  in  1  one-cycle pulse: new sample available
audio_sample  in  SAMPLE_W  signed sample, valid with sample_strobe
cfg_we  in  1  coefficient write enable
cfg_addr  in  4  even = A of band addr>>1, odd = B of band addr>>1
cfg_data  in  COEF_W  signed coefficient
mul_req  out  1  multiplier request
mul_a  out  COEF_W  signed coefficient operand
mul_b  out  STATE_W  signed data operand
mul_gnt  in  1  request accepted this cycle
mul_done  in  1  product valid (one pulse per grant)
mul_p  in  COEF_W+STATE_W  signed product
band_out  out  NUM_BANDS*STATE_W  packed y registers, band 0 in LSBs
band_valid  out  1  one-cycle pulse: band_out updated
busy  out  1  high whenever state != IDLE
overrun  out  1  sticky: a strobe was dropped
overrun_clr  in  1  clears overrun

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset state: IDLE, all s[b] and y[b] cleared to 0, and every output driven 0.
- Coefficients reset to A = {20,15,10,5} and B = {10,25,30,40} for bands 0..3. Bands 4..7 reset to A=0, B=0.
- FSM states: IDLE, FB_REQ, FB_WAIT, FF_REQ, FF_WAIT, DONE.
- IDLE: on sample_strobe, capture x = audio_sample, set b = 0, go to FB_REQ.
- FB_REQ: drive mul_req=1, mul_a=A[b], mul_b=y[b]. Operands are registered on entry and held stable until mul_gnt. On mul_gnt go to FB_WAIT (mul_req is low in FB_WAIT).
- FB_WAIT: on mul_done, fb = mul_p >>> 8, truncated to STATE_W. Go to FF_REQ.
- FF_REQ: drive mul_a=B[b], mul_b=sign-extended x. Same handshake as FB_REQ.
- FF_WAIT: on mul_done, ff = mul_p >>> 8 (truncated). Then update y[b] <= s[b] and s[b] <= sat(s[b] - fb + ff).
  - The sum is computed at STATE_W+2 bits and saturated to [-32768, 32767]. It never wraps.
  - If b == NUM_BANDS-1, go to DONE. Otherwise b++ and go to FB_REQ.
- DONE: band_valid=1 for exactly this cycle, then go to IDLE.
- Latency: with mul_gnt tied high and mul_done one cycle after grant, band_valid is high 4*NUM_BANDS+1 cycles after the strobe edge (17 for the default). Each grant stall or done stall cycle adds one cycle.
- Overrun: sample_strobe while busy (including DONE) drops that sample and sets overrun. overrun_clr clears it. If overrun_clr and a drop happen in the same cycle, the set wins.
- Config: cfg_we is accepted in any state. A new coefficient is used only at the next FB_REQ/FF_REQ operand load and never alters an in-flight request. Writes with cfg_addr >= 2*NUM_BANDS are ignored.
- mul_done outside FB_WAIT/FF_WAIT is ignored. rst in any state aborts the sequence, so a late mul_done after reset is ignored.
- band_out reflects the y registers continuously; it changes only in FF_WAIT update cycles.

Decomposition:
- Shared package spectrum_pkg holds:
  - the FSM state enum;
  - widths SAMPLE_W, STATE_W, COEF_W, PROD_W = 24;
  - default coefficient constants;
  - a saturate-to-STATE_W function.
- Sub-module band_coeff_regfile: 2*NUM_BANDS coefficient registers with reset defaults, write port and two combinational read ports (A[b], B[b]).

Test Plan:
- Reset, then default coefficients with states at 0; strobe with x=64 and a zero-wait multiplier model -> band_valid at cycle 17 and band_out all 0. A second strobe with x=64 -> y = {2,6,7,10} for bands 0..3.
- x=-128 with default coefficients, one strobe then another -> y[3] = -20 (-5120>>>8) and y[0] = -5; arithmetic shift verified.
- Write A0=-128 and B0=127 via cfg, then repeated strobes with x=127 -> y[0] increases monotonically and holds at 32767 with no wrap.
- Hold mul_gnt low for 5 cycles during FB_REQ -> mul_req stays high and mul_a/mul_b stay constant; band_valid is delayed by exactly 5 cycles.
- Strobe during busy -> overrun=1, sample dropped and y unchanged by it. overrun_clr -> 0. A simultaneous clr and drop -> 1.
- rst asserted in FF_WAIT -> next cycle busy=0, band_out=0, coefficients back to defaults. A mul_done pulse after reset -> no state change.
